// File: rtl/axi4_defs.sv
// Shared AXI4 definitions for the read and write slave blocks: response codes,
// FSM state encodings, address limit and the reset memory image.
package axi4_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // First byte address past the backing memory; anything at or above is rejected.
  localparam logic [7:0] ADDR_LIMIT  = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_W_DATA = 2'd1,
    ST_W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    ST_R_IDLE = 2'd0,
    ST_R_ADDR = 2'd1,
    ST_R_DATA = 2'd2
  } rd_state_e;

  function automatic logic [31:0] reset_word(input int idx);
    logic [31:0] word_s;
    case (idx)
      0:       word_s = 32'hAAAA_1111;
      1:       word_s = 32'hBBBB_2222;
      2:       word_s = 32'hCCCC_3333;
      3:       word_s = 32'hDDDD_4444;
      default: word_s = 32'h0000_0000;
    endcase
    return word_s;
  endfunction

endpackage

// File: rtl/axi4_wr_mem.sv
// Write-side backing store: DEPTH words, byte-enable synchronous write port,
// asynchronous read port; reset restores the fixed image.
module axi4_wr_mem
  import axi4_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage array with byte-lane write enables and reset image load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_W'(reset_word(i));
      end
    end else if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Asynchronous read port
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/axi4_write_fsm.sv
// AXI4 write slave: single outstanding INCR burst of 1..4 beats into a small
// wrapping word memory, with SLVERR for out-of-range addresses or bad wlast.
module axi4_write_fsm
  import axi4_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [7:0]          awaddr,
  input  logic [1:0]          awlen,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic [1:0]          dbg_idx,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_MAX = ADDR_W'(DEPTH - 1);

  wr_state_e         state_r;
  logic              awready_r;
  logic              wready_r;
  logic              bvalid_r;
  logic [ID_W-1:0]   bid_r;
  logic [1:0]        bresp_r;
  logic [ID_W-1:0]   id_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        len_r;
  logic [1:0]        beat_r;
  logic              oor_r;
  logic              err_r;

  logic              w_fire_s;
  logic              last_beat_s;
  logic              wlast_bad_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] idx_next_s;

  // Beat qualification and wrapping index; wready is only ever high in W_DATA
  always_comb begin
    w_fire_s    = wvalid && wready_r;
    last_beat_s = (beat_r == len_r);
    wlast_bad_s = (wlast != last_beat_s);
    mem_we_s    = w_fire_s && !oor_r;
    idx_next_s  = (idx_r == IDX_MAX) ? {ADDR_W{1'b0}} : idx_r + ADDR_W'(1);
  end

  // Transaction FSM with registered handshake and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {ID_W{1'b0}};
      bresp_r   <= 2'b00;
      id_r      <= {ID_W{1'b0}};
      idx_r     <= {ADDR_W{1'b0}};
      len_r     <= 2'b00;
      beat_r    <= 2'b00;
      oor_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          awready_r <= 1'b1;
          if (awvalid && awready_r) begin
            id_r      <= awid;
            idx_r     <= awaddr[2 +: ADDR_W];
            len_r     <= awlen;
            oor_r     <= (awaddr >= ADDR_LIMIT);
            err_r     <= 1'b0;
            beat_r    <= 2'b00;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            state_r   <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_fire_s) begin
            idx_r  <= idx_next_s;
            beat_r <= beat_r + 2'd1;
            err_r  <= err_r || wlast_bad_s;
            // Burst length comes from awlen alone; wlast only feeds the error flag
            if (last_beat_s) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              bid_r    <= id_r;
              bresp_r  <= (oor_r || err_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
              state_r  <= ST_W_RESP;
            end
          end
        end
        ST_W_RESP: begin
          if (bvalid_r && bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;

  axi4_wr_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we_s),
    .waddr(idx_r),
    .wdata(wdata),
    .wstrb(wstrb),
    .raddr(dbg_idx),
    .rdata(dbg_data)
  );

endmodule
